// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared widths, opcodes, FSM states and flag indices for the rf sequencer
package rf_ctrl_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

endpackage

// File: rtl/rf_alu.sv
// rtl/rf_alu.sv - combinational ALU: (op, a, b, imm) -> (result, carry, zero)
module rf_alu
  import rf_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      // Subtract as A + ~B + 1 so carry reads as "no borrow".
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// rtl/rf_op_sequencer.sv - 4-cycle IDLE/READ/EXEC/WRITE sequencer owning all register file ports
module rf_op_sequencer
  import rf_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_srca,
  input  logic [AW-1:0] instr_srcb,
  input  logic [DW-1:0] instr_imm,
  output logic          rf_wr,
  output logic [AW-1:0] rf_da,
  output logic [DW-1:0] rf_din,
  output logic [AW-1:0] rf_aa,
  output logic [AW-1:0] rf_ba,
  input  logic [DW-1:0] rf_data_a,
  input  logic [DW-1:0] rf_data_b,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [1:0]    res_flags,
  output logic          err_r0
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] dst_q, dst_d, srca_q, srca_d, srcb_q, srcb_d;
  logic [DW-1:0] imm_q, imm_d, opa_q, opa_d, opb_q, opb_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [1:0]    res_flags_q, res_flags_d;

  logic [DW-1:0] alu_result;
  logic          alu_carry, alu_zero;
  logic          write_slot;

  rf_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    imm_d       = imm_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_READ;
          op_d    = op_e'(instr_op);
          dst_d   = instr_dst;
          srca_d  = instr_srca;
          srcb_d  = instr_srcb;
          imm_d   = instr_imm;
        end
      end
      ST_READ: begin
        opa_d   = rf_data_a;
        opb_d   = rf_data_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_data_d                  = alu_result;
        res_flags_d[FLAG_CARRY]     = alu_carry;
        res_flags_d[FLAG_ZERO]      = alu_zero;
        state_d                     = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      dst_q       <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      imm_q       <= imm_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

  // Every strobe below depends only on flops, so none can glitch from upstream inputs.
  assign write_slot  = (state_q == ST_WRITE) && (op_q != OP_NOP);
  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_WRITE);
  assign rf_wr       = write_slot && (dst_q != '0);
  assign err_r0      = write_slot && (dst_q == '0);
  assign rf_da       = (state_q == ST_WRITE) ? dst_q : '0;
  assign rf_din      = (state_q == ST_WRITE) ? res_data_q : '0;
  assign rf_aa       = (state_q == ST_READ) ? srca_q : '0;
  assign rf_ba       = (state_q == ST_READ) ? srcb_q : '0;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;

endmodule

// File: doc/rf_op_sequencer.md
# rf_op_sequencer

Multicycle operation sequencer that owns all ports of the 16×8 register file (two asynchronous read ports, one synchronous write port). It accepts one register-to-register or immediate operation per valid/ready handshake and drives read addresses, captures operands, computes the result and performs the write-back. It enforces the R0-is-read-only rule, so no upstream logic ever drives the register file directly.

## Interface
Parameters:
- DW, 8, data width; matches register file word width.
- AW, 4, register address width (16 registers).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset; shared with the register file.
- instr_valid  in  1  operation request valid.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 NOP.
- instr_dst  in  AW  destination register.
- instr_srca  in  AW  source A register.
- instr_srcb  in  AW  source B register.
- instr_imm  in  DW  immediate for LDI.
- rf_wr  out  1  register file write enable.
- rf_da  out  AW  register file write address.
- rf_din  out  DW  register file write data.
- rf_aa  out  AW  register file read address A.
- rf_ba  out  AW  register file read address B.
- rf_data_a  in  DW  register file read data A (combinational from rf_aa).
- rf_data_b  in  DW  register file read data B (combinational from rf_ba).
- res_valid  out  1  one-cycle pulse; result of the completed operation on res_data.
- res_data  out  DW  last result; held until next completion.
- res_flags  out  2  {carry, zero} of last result; held until next completion.
- err_r0  out  1  one-cycle pulse: operation targeted R0 and was suppressed.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE. Transitions: IDLE→READ on instr_valid & instr_ready; READ→EXEC, EXEC→WRITE, WRITE→IDLE unconditionally.
- Accept (IDLE edge): latch op, dst, srca, srcb, imm into internal registers. Inputs may change freely afterwards.
- READ: rf_aa = latched srca, rf_ba = latched srcb; capture rf_data_a/rf_data_b into operand registers at end of cycle. rf_aa/rf_ba are 0 in all other states.
- EXEC: compute result and flags from operand registers; register them.
- ADD: A+B, carry = bit DW of 9-bit sum. SUB: A+~B+1, carry = bit DW (1 = no borrow). AND/OR/XOR: bitwise, carry 0. MOV: result A, carry 0. LDI: result imm, carry 0. zero = (result == 0). Results truncate to DW bits.
- WRITE: rf_da = latched dst, rf_din = result, rf_wr = 1 only if dst ≠ 0 and op ≠ NOP. If dst = 0 and op ≠ NOP: rf_wr = 0, err_r0 = 1. res_valid = 1 for every op including NOP; res_data/res_flags update at this cycle's start (registered from EXEC).
- NOP: full 4-cycle pass, no write, no err_r0, result 0, flags {0,1}.
- Reads of R0 are legal and return 0.

## Timing
- Accept at edge E0 → READ in cycle 1, EXEC cycle 2, WRITE cycle 3; register file updated at edge ending cycle 3; instr_ready high again in cycle 4.
- Throughput: one operation per 4 cycles; instr_ready low for exactly 3 cycles after each accept.
- Back-to-back dependent ops need no forwarding: write completes before next READ.
- Reset values: state IDLE, instr_ready 1, rf_wr 0, rf_da/rf_din/rf_aa/rf_ba 0, res_valid 0, res_data 0, res_flags 00, err_r0 0.
- rst mid-operation: state returns to IDLE immediately (asynchronous); pending write is abandoned, rf_wr drops in the same cycle, no res_valid.
- instr_valid high with instr_ready low: ignored, not queued.
- rf_wr, err_r0, res_valid, instr_ready decode from state register only (glitch-free, no input paths).

## Structure
- Package rf_ctrl_pkg: DW/AW defaults, opcode enum, FSM state enum, flag bit indices.
- Sub-module rf_alu: combinational (op, a, b, imm) → (result, carry, zero); sequencer instantiates it once in EXEC path.

## Test plan
- LDI R1,0x5A; LDI R2,0xA5; ADD R3,R1,R2 → R3 = 0xFF, flags {0,0}, res_valid once per op.
- LDI R5,0xFF; LDI R6,0x01; ADD R7,R5,R6 → R7 = 0x00, flags {1,1}.
- SUB R4,R1,R1 → R4 = 0x00, flags {1,1}; SUB R4,R6,R5 (0x01−0xFF) → 0x02, carry 0.
- LDI R0,0x33 → rf_wr stays 0, err_r0 pulses in WRITE cycle, read of R0 returns 0x00.
- instr_valid held high with 3 queued ops → accepts at cycles 0, 4, 8; instr_ready low cycles 1–3, 5–7.
- Assert rst during EXEC of LDI R9,0x77 → no rf_wr, no res_valid, instr_ready 1 after release, R9 = 0x00.
